// File: rtl/mem_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_loader_pkg
// Description : Shared types and constants for the memory loader. Holds the
//               session state encoding, the default address step and memory
//               depths, and small helpers for length clamping and picking the
//               next non-empty session phase.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package mem_loader_pkg;

    localparam int unsigned DEF_ADDR_STEP  = 4;
    localparam int unsigned DEF_IMEM_DEPTH = 512;
    localparam int unsigned DEF_DMEM_DEPTH = 1024;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD_I    = 3'd1,
        ST_LOAD_D    = 3'd2,
        ST_RUN       = 3'd3,
        ST_DUMP_RD   = 3'd4,
        ST_DUMP_WAIT = 3'd5,
        ST_DUMP_OUT  = 3'd6
    } state_t;

    // Requests longer than the target memory are cut down to its depth.
    function automatic logic [15:0] clamp_len(input logic [15:0] len,
                                              input int unsigned depth);
        if ({16'd0, len} > depth) begin
            return depth[15:0];
        end
        return len;
    endfunction

    // Phases run in fixed order; empty ones are skipped, and when nothing is
    // left the session ends in IDLE.
    function automatic state_t first_phase(input logic i_nz, input logic d_nz,
                                           input logic r_nz, input logic u_nz);
        if (i_nz) return ST_LOAD_I;
        if (d_nz) return ST_LOAD_D;
        if (r_nz) return ST_RUN;
        if (u_nz) return ST_DUMP_RD;
        return ST_IDLE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_loader_ext.sv
`default_nettype none
// ============================================================================
// Module      : ext_port_drv
// Description : Drives one memory's external port. Address and write data
//               are forced to zero unless an access is active; a write
//               request always wins over a read so both enables are never
//               high together. Read data returned one cycle after a read
//               enable is captured and held on rdata_o.
// Ports       : clk, arst       - clock, async active-high reset
//               we_i, re_i      - write / read request for this cycle
//               idx_i           - word index (address = idx_i * ADDR_STEP)
//               wdata_i         - word to write
//               rdata_i         - memory read data (one cycle after ren_o)
//               addr_o, wdata_o, wen_o, ren_o - memory port outputs
//               rdata_o         - last captured read word
// Revision    : 1.0 - initial release
// ============================================================================
module ext_port_drv #(
    parameter int unsigned ADDR_STEP = 4
) (
    input  logic        clk,
    input  logic        arst,
    input  logic        we_i,
    input  logic        re_i,
    input  logic [15:0] idx_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] addr_o,
    output logic [31:0] wdata_o,
    output logic        wen_o,
    output logic        ren_o,
    output logic [31:0] rdata_o
);

    localparam logic [31:0] c_step = ADDR_STEP[31:0];

    logic        w_ren;
    logic        rd_pend_q;
    logic [31:0] rdata_q;

    assign w_ren   = re_i & ~we_i;
    assign wen_o   = we_i;
    assign ren_o   = w_ren;
    assign addr_o  = (we_i | w_ren) ? ({16'd0, idx_i} * c_step) : 32'd0;
    assign wdata_o = we_i ? wdata_i : 32'd0;
    assign rdata_o = rdata_q;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            rd_pend_q <= 1'b0;
            rdata_q   <= 32'd0;
        end else begin
            rd_pend_q <= w_ren;
            if (rd_pend_q) begin
                rdata_q <= rdata_i;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_loader.sv
`default_nettype none
// ============================================================================
// Module      : mem_loader
// Description : Session controller that streams words into instruction and
//               data memory, enables the CPU for a fixed number of cycles and
//               streams data-memory words back out. Optional macro
//               LOADER_CHECKSUM_EN adds a running 32-bit checksum output.
// Ports       : clk, arst          - clock, async active-high reset
//               start + lengths    - session request (latched in IDLE)
//               s_valid/s_data/s_ready - load stream
//               m_valid/m_data/m_ready - dump stream
//               cpu_enable         - CPU run enable
//               *_ext / *_ext_2    - instruction / data memory ports
//               busy, done         - session status
//               checksum           - (LOADER_CHECKSUM_EN only) word sum
// Revision    : 1.0 - initial release
// ============================================================================
module mem_loader
    import mem_loader_pkg::*;
#(
    parameter int unsigned ADDR_STEP  = DEF_ADDR_STEP,
    parameter int unsigned IMEM_DEPTH = DEF_IMEM_DEPTH,
    parameter int unsigned DMEM_DEPTH = DEF_DMEM_DEPTH
) (
    input  logic        clk,
    input  logic        arst,
    input  logic        start,
    input  logic [15:0] imem_len,
    input  logic [15:0] dmem_len,
    input  logic [31:0] run_cycles,
    input  logic [15:0] dump_len,
    input  logic        s_valid,
    input  logic [31:0] s_data,
    output logic        s_ready,
    output logic        m_valid,
    output logic [31:0] m_data,
    input  logic        m_ready,
    output logic        cpu_enable,
    output logic [31:0] addr_ext,
    output logic [31:0] wdata_ext,
    output logic        wen_ext,
    output logic        ren_ext,
    input  logic [31:0] rdata_ext,
    output logic [31:0] addr_ext_2,
    output logic [31:0] wdata_ext_2,
    output logic        wen_ext_2,
    output logic        ren_ext_2,
    input  logic [31:0] rdata_ext_2,
    output logic        busy,
    output logic        done
`ifdef LOADER_CHECKSUM_EN
    ,
    output logic [31:0] checksum
`endif
);

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [15:0] ilen_q, dlen_q, ulen_q;
    logic [31:0] run_q;
    logic        done_q, done_d;

    logic [15:0] w_ilen, w_dlen, w_ulen;
    logic        w_start_ok;
    logic        w_acc;
    logic [31:0] w_cur_len;
    logic        w_last;
    logic        w_we_i, w_we_d, w_re_d;
    logic [31:0] w_rdata_i, w_rdata_d;

    assign w_ilen     = clamp_len(imem_len, IMEM_DEPTH);
    assign w_dlen     = clamp_len(dmem_len, DMEM_DEPTH);
    assign w_ulen     = clamp_len(dump_len, DMEM_DEPTH);
    assign w_start_ok = start && (state_q == ST_IDLE);
    assign w_acc      = s_valid && s_ready;

    // Length of the phase currently running; one counter serves all phases.
    always_comb begin
        w_cur_len = 32'd0;
        case (state_q)
            ST_LOAD_I:                             w_cur_len = {16'd0, ilen_q};
            ST_LOAD_D:                             w_cur_len = {16'd0, dlen_q};
            ST_RUN:                                w_cur_len = run_q;
            ST_DUMP_RD, ST_DUMP_WAIT, ST_DUMP_OUT: w_cur_len = {16'd0, ulen_q};
            default:                               w_cur_len = 32'd0;
        endcase
    end
    assign w_last = (cnt_q == (w_cur_len - 32'd1));

    // State register and session datapath
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 32'd0;
            done_q  <= 1'b0;
            ilen_q  <= 16'd0;
            dlen_q  <= 16'd0;
            ulen_q  <= 16'd0;
            run_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            if (w_start_ok) begin
                ilen_q <= w_ilen;
                dlen_q <= w_dlen;
                ulen_q <= w_ulen;
                run_q  <= run_cycles;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = first_phase(|w_ilen, |w_dlen, |run_cycles, |w_ulen);
                end
            end
            ST_LOAD_I: begin
                if (w_acc) begin
                    cnt_d = w_last ? 32'd0 : cnt_q + 32'd1;
                    if (w_last) state_d = first_phase(1'b0, |dlen_q, |run_q, |ulen_q);
                end
            end
            ST_LOAD_D: begin
                if (w_acc) begin
                    cnt_d = w_last ? 32'd0 : cnt_q + 32'd1;
                    if (w_last) state_d = first_phase(1'b0, 1'b0, |run_q, |ulen_q);
                end
            end
            ST_RUN: begin
                cnt_d = w_last ? 32'd0 : cnt_q + 32'd1;
                if (w_last) state_d = first_phase(1'b0, 1'b0, 1'b0, |ulen_q);
            end
            ST_DUMP_RD:   state_d = ST_DUMP_WAIT;
            ST_DUMP_WAIT: state_d = ST_DUMP_OUT;
            ST_DUMP_OUT: begin
                if (m_ready) begin
                    cnt_d   = w_last ? 32'd0 : cnt_q + 32'd1;
                    state_d = w_last ? ST_IDLE : ST_DUMP_RD;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 32'd0;
            end
        endcase
        // done marks the first IDLE cycle after a session, including an
        // empty session that never leaves IDLE.
        done_d = (state_d == ST_IDLE) && ((state_q != ST_IDLE) || start);
    end

    // Output decode
    always_comb begin
        s_ready    = 1'b0;
        m_valid    = 1'b0;
        cpu_enable = 1'b0;
        busy       = 1'b1;
        w_we_i     = 1'b0;
        w_we_d     = 1'b0;
        w_re_d     = 1'b0;
        case (state_q)
            ST_IDLE:     busy = 1'b0;
            ST_LOAD_I: begin
                s_ready = 1'b1;
                w_we_i  = s_valid;
            end
            ST_LOAD_D: begin
                s_ready = 1'b1;
                w_we_d  = s_valid;
            end
            ST_RUN:      cpu_enable = 1'b1;
            ST_DUMP_RD:  w_re_d = 1'b1;
            ST_DUMP_OUT: m_valid = 1'b1;
            default:     busy = 1'b1;
        endcase
    end

    assign done = done_q;

    ext_port_drv #(.ADDR_STEP(ADDR_STEP)) u_imem_drv (
        .clk     (clk),
        .arst    (arst),
        .we_i    (w_we_i),
        .re_i    (1'b0),
        .idx_i   (cnt_q[15:0]),
        .wdata_i (s_data),
        .rdata_i (rdata_ext),
        .addr_o  (addr_ext),
        .wdata_o (wdata_ext),
        .wen_o   (wen_ext),
        .ren_o   (ren_ext),
        .rdata_o (w_rdata_i)
    );

    ext_port_drv #(.ADDR_STEP(ADDR_STEP)) u_dmem_drv (
        .clk     (clk),
        .arst    (arst),
        .we_i    (w_we_d),
        .re_i    (w_re_d),
        .idx_i   (cnt_q[15:0]),
        .wdata_i (s_data),
        .rdata_i (rdata_ext_2),
        .addr_o  (addr_ext_2),
        .wdata_o (wdata_ext_2),
        .wen_o   (wen_ext_2),
        .ren_o   (ren_ext_2),
        .rdata_o (w_rdata_d)
    );

    // The instruction port never issues reads, so its capture register stays
    // zero; merging it keeps both driver instances identical.
    assign m_data = w_rdata_d | w_rdata_i;

`ifdef LOADER_CHECKSUM_EN
    logic [31:0] csum_q;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            csum_q <= 32'd0;
        end else if (w_start_ok) begin
            csum_q <= 32'd0;
        end else if (w_acc) begin
            csum_q <= csum_q + s_data;
        end else if (m_valid && m_ready) begin
            csum_q <= csum_q + m_data;
        end
    end

    assign checksum = csum_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_loader
// Description : Self-checking bench for mem_loader. Sessions push expected
//               memory writes, dump words, run length and checksum into
//               queues; a monitor pops and compares on every DUT event.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_loader;

    localparam int IMEM_D = 8;
    localparam int DMEM_D = 8;

    logic        clk, arst, start;
    logic [15:0] imem_len, dmem_len, dump_len;
    logic [31:0] run_cycles;
    logic        s_valid, s_ready, m_valid, m_ready;
    logic [31:0] s_data, m_data;
    logic        cpu_enable, busy, done;
    logic [31:0] addr_ext, wdata_ext, rdata_ext;
    logic        wen_ext, ren_ext;
    logic [31:0] addr_ext_2, wdata_ext_2, rdata_ext_2;
    logic        wen_ext_2, ren_ext_2;
`ifdef LOADER_CHECKSUM_EN
    logic [31:0] checksum;
`endif

    mem_loader #(.ADDR_STEP(4), .IMEM_DEPTH(IMEM_D), .DMEM_DEPTH(DMEM_D)) dut (
        .clk(clk), .arst(arst), .start(start),
        .imem_len(imem_len), .dmem_len(dmem_len), .run_cycles(run_cycles),
        .dump_len(dump_len),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
        .cpu_enable(cpu_enable),
        .addr_ext(addr_ext), .wdata_ext(wdata_ext), .wen_ext(wen_ext),
        .ren_ext(ren_ext), .rdata_ext(rdata_ext),
        .addr_ext_2(addr_ext_2), .wdata_ext_2(wdata_ext_2),
        .wen_ext_2(wen_ext_2), .ren_ext_2(ren_ext_2), .rdata_ext_2(rdata_ext_2),
        .busy(busy), .done(done)
`ifdef LOADER_CHECKSUM_EN
        , .checksum(checksum)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- data memory model ----------------
    logic [31:0] mem_d [0:255];
    logic        mem_clr;
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) mem_d[i] <= 32'd0;
        end else if (wen_ext_2) begin
            mem_d[addr_ext_2[9:2]] <= wdata_ext_2;
        end
        if (ren_ext_2) rdata_ext_2 <= mem_d[addr_ext_2[9:2]];
    end

    // ---------------- reference model / scoreboard ----------------
    logic [31:0] ref_dmem [0:255];
    logic [31:0] exp_i_addr[$], exp_i_data[$];
    logic [31:0] exp_d_addr[$], exp_d_data[$];
    logic [31:0] exp_dump[$], exp_sum[$];
    int          exp_run[$];
    logic [31:0] fixed_words[$];

    bit done_seen, sess_over;

    // ---------------- monitor ----------------
    int          run_cnt = 0;
    logic        prev_mv = 0, prev_mr = 0, prev_cpu = 0, prev_done = 0;
    logic [31:0] prev_md = 0;

    always @(negedge clk) begin
        if (arst) begin
            run_cnt  = 0;
            prev_mv  = 0;
            prev_mr  = 0;
            prev_cpu = 0;
            prev_done = 0;
        end else begin
            if (wen_ext || ren_ext)
                chk("imem_enable_excl", {31'd0, wen_ext & ren_ext}, 32'd0);
            if (wen_ext_2 || ren_ext_2)
                chk("dmem_enable_excl", {31'd0, wen_ext_2 & ren_ext_2}, 32'd0);
            if (wen_ext) begin
                chk("imem_write_expected", {31'd0, exp_i_addr.size() != 0}, 32'd1);
                if (exp_i_addr.size() != 0) begin
                    chk("imem_addr", addr_ext, exp_i_addr.pop_front());
                    chk("imem_data", wdata_ext, exp_i_data.pop_front());
                end
            end
            if (wen_ext_2) begin
                chk("dmem_write_expected", {31'd0, exp_d_addr.size() != 0}, 32'd1);
                if (exp_d_addr.size() != 0) begin
                    chk("dmem_addr", addr_ext_2, exp_d_addr.pop_front());
                    chk("dmem_data", wdata_ext_2, exp_d_data.pop_front());
                end
            end
            if (cpu_enable) begin
                if (!prev_cpu) chk("run_contiguous", 32'(run_cnt), 32'd0);
                run_cnt++;
            end
            if (prev_mv && !prev_mr) begin
                chk("m_valid_hold", {31'd0, m_valid}, 32'd1);
                chk("m_data_hold", m_data, prev_md);
            end
            if (m_valid && m_ready) begin
                chk("dump_expected", {31'd0, exp_dump.size() != 0}, 32'd1);
                if (exp_dump.size() != 0) chk("dump_data", m_data, exp_dump.pop_front());
            end
            if (done) begin
                done_seen = 1;
                chk("done_pulse_width", {31'd0, prev_done}, 32'd0);
                chk("done_expected", {31'd0, exp_run.size() != 0}, 32'd1);
                if (exp_run.size() != 0) begin
                    chk("run_cycles", 32'(run_cnt), 32'(exp_run.pop_front()));
`ifdef LOADER_CHECKSUM_EN
                    chk("checksum", checksum, exp_sum.pop_front());
`else
                    void'(exp_sum.pop_front());
`endif
                end
                chk("imem_writes_left", 32'(exp_i_addr.size()), 32'd0);
                chk("dmem_writes_left", 32'(exp_d_addr.size()), 32'd0);
                chk("dump_words_left", 32'(exp_dump.size()), 32'd0);
                run_cnt = 0;
            end
            prev_mv   = m_valid;
            prev_mr   = m_ready;
            prev_md   = m_data;
            prev_cpu  = cpu_enable;
            prev_done = done;
        end
    end

    // ---------------- helpers ----------------
    task automatic check_quiet(input string tag);
        chk({tag, "_s_ready"},    {31'd0, s_ready},    32'd0);
        chk({tag, "_m_valid"},    {31'd0, m_valid},    32'd0);
        chk({tag, "_cpu_enable"}, {31'd0, cpu_enable}, 32'd0);
        chk({tag, "_busy"},       {31'd0, busy},       32'd0);
        chk({tag, "_done"},       {31'd0, done},       32'd0);
        chk({tag, "_wen"},        {31'd0, wen_ext},    32'd0);
        chk({tag, "_ren"},        {31'd0, ren_ext},    32'd0);
        chk({tag, "_wen2"},       {31'd0, wen_ext_2},  32'd0);
        chk({tag, "_ren2"},       {31'd0, ren_ext_2},  32'd0);
        chk({tag, "_m_data"},     m_data,              32'd0);
        chk({tag, "_addr2"},      addr_ext_2,          32'd0);
    endtask

    // gap: 0 always valid, 1 every other cycle, 2 random.
    // stall: <0 random m_ready, else m_ready low for that many cycles per word.
    task automatic session(input int il, input int dl, input int rc, input int ul,
                           input int gap, input int stall);
        int li, ld, lu, n;
        logic [31:0] words[$];
        logic [31:0] sum, w;
        li = (il > IMEM_D) ? IMEM_D : il;
        ld = (dl > DMEM_D) ? DMEM_D : dl;
        lu = (ul > DMEM_D) ? DMEM_D : ul;
        n  = li + ld;
        sum = 32'd0;
        for (int k = 0; k < n; k++) begin
            w = (fixed_words.size() != 0) ? fixed_words.pop_front() : $urandom;
            words.push_back(w);
            sum += w;
        end
        for (int k = 0; k < li; k++) begin
            exp_i_addr.push_back(32'(4 * k));
            exp_i_data.push_back(words[k]);
        end
        for (int k = 0; k < ld; k++) begin
            exp_d_addr.push_back(32'(4 * k));
            exp_d_data.push_back(words[li + k]);
            ref_dmem[k] = words[li + k];
        end
        for (int k = 0; k < lu; k++) begin
            exp_dump.push_back(ref_dmem[k]);
            sum += ref_dmem[k];
        end
        exp_run.push_back(rc);
        exp_sum.push_back(sum);

        done_seen = 0;
        sess_over = 0;
        @(posedge clk); #1;
        start = 1; imem_len = 16'(il); dmem_len = 16'(dl);
        run_cycles = 32'(rc); dump_len = 16'(ul);
        @(posedge clk); #1;
        start = 0;
        // Scramble the request inputs: the session must use latched values.
        imem_len = 16'($urandom); dmem_len = 16'($urandom);
        run_cycles = $urandom; dump_len = 16'($urandom);
        fork
            begin : feed
                int sent, t;
                sent = 0; t = 0;
                while (!sess_over) begin
                    @(posedge clk); #1;
                    if (sess_over) break;
                    if (sent < n) begin
                        case (gap)
                            0:       s_valid = 1'b1;
                            1:       s_valid = (t % 2) == 0;
                            default: s_valid = 1'($urandom_range(0, 1));
                        endcase
                        s_data = words[sent];
                    end else begin
                        s_valid = 1'($urandom_range(0, 1));
                        s_data  = $urandom;
                    end
                    t++;
                    @(negedge clk);
                    if (s_valid && s_ready && sent < n) sent++;
                end
                s_valid = 0;
            end
            begin : mrdy
                int low;
                low = 0;
                while (!sess_over) begin
                    @(posedge clk); #1;
                    if (sess_over) break;
                    if (m_valid) begin
                        if (stall < 0) m_ready = 1'($urandom_range(0, 1));
                        else if (low < stall) begin
                            m_ready = 0;
                            low++;
                        end else m_ready = 1;
                    end else begin
                        m_ready = 1'($urandom_range(0, 1));
                    end
                    @(negedge clk);
                    if (m_valid && m_ready) low = 0;
                end
                m_ready = 0;
            end
            begin : waiter
                int cyc;
                cyc = 0;
                while (!done_seen && cyc < 3000) begin
                    @(negedge clk);
                    cyc++;
                    // A second start while busy must be ignored.
                    start = (cyc == 3) && busy;
                end
                start = 0;
                if (!done_seen) chk("session_timeout", 32'(cyc), 32'd0);
                sess_over = 1;
            end
        join
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] w0, w1;
        clk = 0; arst = 1; start = 0; mem_clr = 1;
        imem_len = 0; dmem_len = 0; run_cycles = 0; dump_len = 0;
        s_valid = 0; s_data = 0; m_ready = 0; rdata_ext = 32'hC0DE_0000;
        done_seen = 0; sess_over = 0;
        for (int i = 0; i < 256; i++) ref_dmem[i] = 32'd0;
        #2;
        check_quiet("reset");
        @(negedge clk); @(negedge clk);
        mem_clr = 0;
        arst = 0;

        // Three instruction words at addresses 0,4,8.
        fixed_words = '{32'h11, 32'h22, 32'h33};
        session(3, 0, 0, 0, 0, 0);
        // Data load with s_valid toggling.
        session(0, 2, 0, 0, 1, 0);
        // Run only.
        session(0, 0, 5, 0, 0, 0);
        // Empty session.
        session(0, 0, 0, 0, 0, 0);
        // Load A,B then dump them with a 3-cycle stall per word.
        fixed_words = '{32'hA, 32'hB};
        session(0, 2, 0, 2, 0, 3);
        // Load 1,2,3 and dump one word: checksum 7.
        fixed_words = '{32'd1, 32'd2, 32'd3};
        session(0, 3, 0, 1, 0, 0);
        // Clamped lengths.
        session(12, 11, 2, 20, 2, -1);

        // Reset in the middle of a data load.
        w0 = $urandom; w1 = $urandom;
        exp_d_addr.push_back(32'd0); exp_d_data.push_back(w0);
        exp_d_addr.push_back(32'd4); exp_d_data.push_back(w1);
        ref_dmem[0] = w0; ref_dmem[1] = w1;
        @(posedge clk); #1;
        start = 1; imem_len = 0; dmem_len = 4; run_cycles = 0; dump_len = 0;
        @(posedge clk); #1;
        start = 0; s_valid = 1; s_data = w0;
        @(posedge clk); #1;
        s_data = w1;
        @(posedge clk); #1;
        s_data = $urandom;
        #2 arst = 1;
        #1 check_quiet("arst");
        chk("arst_pending_writes", 32'(exp_d_addr.size()), 32'd0);
        @(negedge clk);
        arst = 0;
        // No activity without a fresh start, even with s_valid held.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("post_reset_idle_busy", {31'd0, busy}, 32'd0);
        end
        s_valid = 0;
        session(0, 2, 0, 3, 0, 1);

        // Randomized sessions.
        for (int r = 0; r < 20; r++) begin
            session($urandom_range(0, 10), $urandom_range(0, 10),
                    $urandom_range(0, 6), $urandom_range(0, 10),
                    $urandom_range(0, 2), $urandom_range(0, 3) - 1);
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
